// File: rtl/led_step_ctrl.sv
// led_step_ctrl: debounced run/dir/step keys driving a wrapping LED position index.
module led_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int STEP_CYCLES     = 8192,
   parameter int LAST_STATE      = 9
) (
   input  logic       clk_50M,
   input  logic       reset,
   input  logic       key_run,
   input  logic       key_dir,
   input  logic       key_step,
   output logic [3:0] state,
   output logic       step_pulse,
   output logic       running,
   output logic       dir
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
   localparam logic [3:0] LAST = 4'(LAST_STATE);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} fsm_t;
   logic [2:0] keys, sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   fsm_t fsm_q, fsm_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [3:0] state_q, state_d, nxt;
   logic dir_q, dir_d, running_q, running_d, step_pulse_q, step_pulse_d;
   logic run_p, dir_p, step_p, tick, adv;
   assign keys = {key_step, key_dir, key_run};
   assign run_p = press_q[0];
   assign dir_p = press_q[1];
   assign step_p = press_q[2];
   assign tick = (fsm_q == RUN) && (pre_q == PW'(STEP_CYCLES - 1));
   assign state = state_q;
   assign dir = dir_q;
   assign running = running_q;
   assign step_pulse = step_pulse_q;
   always_ff @(posedge clk_50M) begin
      if (reset) begin
         sync1_q      <= '1;
         sync2_q      <= '1;
         deb_q        <= '1;
         press_q      <= '0;
         for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
         fsm_q        <= IDLE;
         pre_q        <= '0;
         state_q      <= '0;
         dir_q        <= 1'b0;
         running_q    <= 1'b0;
         step_pulse_q <= 1'b0;
      end else begin
         sync1_q      <= keys;
         sync2_q      <= sync1_q;
         deb_q        <= deb_d;
         press_q      <= press_d;
         for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
         fsm_q        <= fsm_d;
         pre_q        <= pre_d;
         state_q      <= state_d;
         dir_q        <= dir_d;
         running_q    <= running_d;
         step_pulse_q <= step_pulse_d;
      end
   end
   // a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         deb_d[k] = deb_q[k];
         cnt_d[k] = '0;
         if (sync2_q[k] != deb_q[k]) begin
            if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) deb_d[k] = sync2_q[k];
            else cnt_d[k] = cnt_q[k] + 1'b1;
         end
      end
      press_d = deb_q & ~deb_d;
   end
   always_comb begin
      fsm_d = run_p ? ((fsm_q == RUN) ? PAUSE : RUN) :
              (step_p && fsm_q == IDLE) ? PAUSE : fsm_q;
   end
   // step presses only count outside RUN, and a run press outranks them
   always_comb begin
      adv          = tick || (fsm_q != RUN && step_p && !run_p);
      nxt          = dir_q ? ((state_q == 4'd0) ? LAST : state_q - 4'd1)
                           : ((state_q == LAST) ? 4'd0 : state_q + 4'd1);
      state_d      = adv ? nxt : state_q;
      dir_d        = dir_q ^ dir_p;
      running_d    = fsm_d == RUN;
      step_pulse_d = adv;
      pre_d        = (fsm_q == RUN && fsm_d == RUN && !tick) ? pre_q + 1'b1 : '0;
   end
endmodule
